hbuf_controller: RTL and testbench
==================================

// Module: hbuf_controller
// PURPOSE
//  Hit-buffer controller: packs readout records from the waveform reader's 256x128b readout DPRAM
//  into 4 KiB pages and hands full pages to the DDR3 writer over a pg_req/pg_ack handshake.
//  Manages a circular ring of DDR3 pages [first_pg..last_pg] with page clear and flush. Single clock domain.
// PARAMETERS
//  P_PG_NUM_W   16  page-number width
//  P_ADDR_W     28  DDR3 byte-address width; pg_addr = {pg_num, 12'h000}
// PORTS
//  clk               in   1    system clock
//  rst_n             in   1    synchronous active-low reset
//  en                in   1    enable; rising edge latches ring bounds
//  start_pg,stop_pg  in   16   ring bounds, inclusive; stop_pg >= start_pg
//  first_pg,last_pg  out  16   latched ring bounds
//  rd_pg_num         out  16   oldest used page
//  wr_pg_num         out  16   next page to write
//  n_used_pgs        out  16   committed, uncleared pages
//  empty,full        out  1    n_used_pgs==0 / ==ring size
//  pg_clr_req,pg_clr_ack  in/out 1  four-phase page-clear handshake
//  pg_clr_cnt        in   16   pages to free per clear
//  flush_req,flush_ack    in/out 1  four-phase flush handshake
//  buffered_data     out  1    partial page held in page RAM
//  dpram_len_in      in   16   record length in 16b words; sampled on dpram_run
//  rdout_dpram_run   in   1    1-cycle pulse: record ready in readout DPRAM
//  dpram_busy        out  1    controller owns readout DPRAM; reader must wait
//  rdout_dpram_wren, rdout_dpram_wr_addr[8], rdout_dpram_data[128]  in  reader write port
//  ddr3_dpram_rd_addr in 8    page-RAM read address, 128b words
//  ddr3_dpram_dout   out  128  page-RAM read data, 1-cycle latency
//  pg_req,pg_ack     out/in 1  four-phase page-transfer handshake
//  pg_optype         out  1    constant 1 (write to DDR3)
//  pg_addr           out  28   {wr_pg_num,12'h000}, stable while pg_req=1
// BEHAVIOUR
//  Reset: pg/ack/busy outputs 0, empty=1, full=0, all counters/bounds 0, FSM IDLE. Mid-operation reset aborts and drops the partial page.
//  en=0: dpram_busy=1 and dpram_run ignored. en 0->1: first/last<=start/stop, rd=wr<=start_pg, n_used<=0.
//  States: IDLE, COPY, PG_REQ, PG_WAIT, FLUSH_PAD, CLR.
//  IDLE->COPY on dpram_run; dpram_busy=1 from the next cycle until the copy completes.
//  COPY: ceil(len/4) 64b half-words, low half of each 128b entry first, 1 per cycle into page fill ptr (0..511).
//  Fill ptr reaching 512: pause COPY, go to PG_REQ, resume at ptr 0 after commit. Records may span pages.
//  PG_REQ: pg_req=1 until pg_ack=1. PG_WAIT: pg_req=0 until pg_ack=0. Then commit.
//  Commit: wr_pg_num++ (last_pg wraps to first_pg), n_used++, fill ptr 0.
//  full: PG_REQ is not entered; FSM and dpram_busy stall until a clear frees a page. No data dropped.
//  Clear (from IDLE): n=min(pg_clr_cnt,n_used); rd_pg_num+=n modulo ring; n_used-=n. pg_clr_ack held until req=0.
//  Flush (from IDLE): if buffered_data, zero-pad to 512 and commit, then ack; otherwise ack next cycle. ack held until req=0.
//  Simultaneous requests in IDLE: priority clear > run > flush.
//  buffered_data = (fill ptr != 0).
//  Page RAM: 64b write / 128b read, built as two 256x64 banks selected by ptr[0].
// CONFIGURATION
//  HBUF_PG_STATS_EN defined: adds output n_pgs_written[31:0], +1 per commit, cleared by reset and en rise.
//  Undefined: port and counter absent.
// STRUCTURE
//  hbuf_pkg: page size 4096 B, 512x64 / 256x128 geometry, FSM state enum.
//  Sub-module hbuf_page_ram: dual-bank page RAM. Readout DPRAM is a plain inferred 256x128 array.
// TESTING
//  start=5, stop=15, en rise -> first_pg=5, last_pg=15, rd=wr=5, empty=1.
//  Runs totalling 2048 words -> pg_req with pg_addr=0x0005000, optype 1; after ack: wr=6, n_used=1.
//  Fill 11 pages -> full=1, busy stalls; clear cnt=100 -> rd=wr=5, n_used=0, pg_clr_ack.
//  12th page written -> pg_addr=0x0005000 (wrap).
//  100 words then flush_req -> page with words 0..99 data, rest 0; flush_ack; buffered_data 1->0.
//  Flush with empty page -> ack in 1 cycle, no pg_req.

Source files
------------

// File: rtl/hbuf_pkg.sv
// Shared geometry and FSM encoding for the hit-buffer controller.
package hbuf_pkg;
   localparam int PG_BYTES  = 4096;
   localparam int PG_OFS_W  = $clog2(PG_BYTES);
   localparam int HW_W      = 64;
   localparam int WD_W      = 128;
   localparam int PG_HW_AW  = 9;
   localparam int PG_WD_NUM = 256;
   localparam int PG_WD_AW  = 8;
   localparam int RD_DEPTH  = 256;
   localparam int RD_AW     = 8;
   localparam int HW_CNT_W  = 15;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COPY      = 3'd1,
      PG_REQ    = 3'd2,
      PG_WAIT   = 3'd3,
      FLUSH_PAD = 3'd4,
      CLR       = 3'd5
   } state_t;

   // Record length in 16b words to 64b half-words, rounded up.
   function automatic logic [HW_CNT_W-1:0] len_to_hw(input logic [15:0] len);
      logic [16:0] t;
      t = {1'b0, len} + 17'd3;
      return t[16:2];
   endfunction
endpackage

// File: rtl/hbuf_page_ram.sv
// Page RAM: 64b write port, 128b registered read port, two 256x64 banks split on ptr[0].
module hbuf_page_ram
   import hbuf_pkg::*;
(
   input  logic                clk,
   input  logic                wr_en,
   input  logic [PG_HW_AW-1:0] wr_addr,
   input  logic [HW_W-1:0]     wr_data,
   input  logic [PG_WD_AW-1:0] rd_addr,
   output logic [WD_W-1:0]     rd_data
);
   logic [HW_W-1:0] bank0_mem [PG_WD_NUM];
   logic [HW_W-1:0] bank1_mem [PG_WD_NUM];
   logic [HW_W-1:0] rd0_q;
   logic [HW_W-1:0] rd1_q;

   always_ff @(posedge clk) begin
      if (wr_en && !wr_addr[0]) bank0_mem[wr_addr[PG_HW_AW-1:1]] <= wr_data;
      if (wr_en &&  wr_addr[0]) bank1_mem[wr_addr[PG_HW_AW-1:1]] <= wr_data;
      rd0_q <= bank0_mem[rd_addr];
      rd1_q <= bank1_mem[rd_addr];
   end

   // Even half-words land in the low 64 bits of each 128b entry.
   assign rd_data = {rd1_q, rd0_q};
endmodule

// File: rtl/hbuf_controller.sv
// Hit-buffer controller: packs readout records into 4 KiB pages for the DDR3 writer over a page ring.
// Define HBUF_PG_STATS_EN to add the n_pgs_written commit counter output.
module hbuf_controller
   import hbuf_pkg::*;
#(
   parameter int P_PG_NUM_W = 16,
   parameter int P_ADDR_W   = 28
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [P_PG_NUM_W-1:0] start_pg,
   input  logic [P_PG_NUM_W-1:0] stop_pg,
   output logic [P_PG_NUM_W-1:0] first_pg,
   output logic [P_PG_NUM_W-1:0] last_pg,
   output logic [P_PG_NUM_W-1:0] rd_pg_num,
   output logic [P_PG_NUM_W-1:0] wr_pg_num,
   output logic [P_PG_NUM_W-1:0] n_used_pgs,
   output logic                  empty,
   output logic                  full,
   input  logic                  pg_clr_req,
   output logic                  pg_clr_ack,
   input  logic [P_PG_NUM_W-1:0] pg_clr_cnt,
   input  logic                  flush_req,
   output logic                  flush_ack,
   output logic                  buffered_data,
   input  logic [15:0]           dpram_len_in,
   input  logic                  rdout_dpram_run,
   output logic                  dpram_busy,
   input  logic                  rdout_dpram_wren,
   input  logic [RD_AW-1:0]      rdout_dpram_wr_addr,
   input  logic [WD_W-1:0]       rdout_dpram_data,
   input  logic [PG_WD_AW-1:0]   ddr3_dpram_rd_addr,
   output logic [WD_W-1:0]       ddr3_dpram_dout,
   output logic                  pg_req,
   input  logic                  pg_ack,
   output logic                  pg_optype,
   output logic [P_ADDR_W-1:0]   pg_addr,
`ifdef HBUF_PG_STATS_EN
   output logic [31:0]           n_pgs_written,
`endif
   output logic [2:0]            dbg_state
);
   localparam int PW = P_PG_NUM_W;

   state_t              state_q, state_d;
   logic                en_q;
   logic [PW-1:0]       first_q, first_d, last_q, last_d;
   logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d, n_used_q, n_used_d;
   logic [PG_HW_AW:0]   fill_q, fill_d;
   logic [HW_CNT_W-1:0] hw_cnt_q, hw_cnt_d, hw_total_q, hw_total_d;
   logic                copy_q, copy_d, flushing_q, flushing_d, busy_q, busy_d;
   logic                clr_ack_q, clr_ack_d, flush_ack_q, flush_ack_d;
`ifdef HBUF_PG_STATS_EN
   logic [31:0]         stats_q, stats_d;
`endif

   logic [PW:0]         ring_size, rd_sum;
   logic [PW-1:0]       rd_wrapped, clr_n, wr_next;
   logic                page_done, full_w, clr_pending, flush_pending, en_rise;
   logic                pg_wr_en;
   logic [HW_W-1:0]     pg_wr_data, rdout_hw;
   logic [WD_W-1:0]     rdout_word;
   logic [WD_W-1:0]     rdout_mem [RD_DEPTH];

   always_ff @(posedge clk) begin
      if (rdout_dpram_wren) rdout_mem[rdout_dpram_wr_addr] <= rdout_dpram_data;
   end

   assign rdout_word = rdout_mem[hw_cnt_q[RD_AW:1]];
   assign rdout_hw   = hw_cnt_q[0] ? rdout_word[WD_W-1:HW_W] : rdout_word[HW_W-1:0];

   assign ring_size  = {1'b0, last_q} - {1'b0, first_q} + (PW+1)'(1);
   assign full_w     = ({1'b0, n_used_q} == ring_size);
   assign clr_n      = (pg_clr_cnt < n_used_q) ? pg_clr_cnt : n_used_q;
   assign rd_sum     = {1'b0, rd_q} + {1'b0, clr_n};
   assign rd_wrapped = (rd_sum > {1'b0, last_q}) ? PW'(rd_sum - ring_size) : rd_sum[PW-1:0];
   assign wr_next    = (wr_q == last_q) ? first_q : wr_q + PW'(1);
   assign page_done  = fill_q[PG_HW_AW];
   // All three handshakes are four-phase: an ack, once raised, stays high until its
   // req falls, and a req is not serviced again while its previous ack is still high.
   assign clr_pending   = pg_clr_req && !clr_ack_q;
   assign flush_pending = flush_req && !flush_ack_q;
   assign en_rise       = en && !en_q;

   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      last_d      = last_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      n_used_d    = n_used_q;
      fill_d      = fill_q;
      hw_cnt_d    = hw_cnt_q;
      hw_total_d  = hw_total_q;
      copy_d      = copy_q;
      flushing_d  = flushing_q;
      clr_ack_d   = clr_ack_q & pg_clr_req;
      flush_ack_d = flush_ack_q & flush_req;
      pg_wr_en    = 1'b0;
      pg_wr_data  = rdout_hw;
`ifdef HBUF_PG_STATS_EN
      stats_d     = stats_q;
`endif
      case (state_q)
         IDLE: begin
            if (clr_pending) begin
               state_d = CLR;
            end else if (en && rdout_dpram_run) begin
               state_d    = COPY;
               hw_total_d = len_to_hw(dpram_len_in);
               hw_cnt_d   = '0;
               copy_d     = 1'b1;
            end else if (flush_pending) begin
               if (fill_q != '0) begin
                  state_d    = FLUSH_PAD;
                  flushing_d = 1'b1;
               end else begin
                  flush_ack_d = 1'b1;
               end
            end
         end
         COPY: begin
            if (page_done) begin
               // A full ring parks here with the page intact; only a clear can release it.
               if (!full_w)          state_d = PG_REQ;
               else if (clr_pending) state_d = CLR;
            end else if (hw_cnt_q == hw_total_q) begin
               state_d = IDLE;
               copy_d  = 1'b0;
            end else begin
               pg_wr_en = 1'b1;
               hw_cnt_d = hw_cnt_q + HW_CNT_W'(1);
               fill_d   = fill_q + (PG_HW_AW+1)'(1);
            end
         end
         FLUSH_PAD: begin
            if (page_done) begin
               if (!full_w)          state_d = PG_REQ;
               else if (clr_pending) state_d = CLR;
            end else begin
               pg_wr_en   = 1'b1;
               pg_wr_data = '0;
               fill_d     = fill_q + (PG_HW_AW+1)'(1);
            end
         end
         PG_REQ: begin
            if (pg_ack) state_d = PG_WAIT;
         end
         PG_WAIT: begin
            if (!pg_ack) begin
               wr_d     = wr_next;
               n_used_d = n_used_q + PW'(1);
               fill_d   = '0;
`ifdef HBUF_PG_STATS_EN
               stats_d  = stats_q + 32'd1;
`endif
               if (flushing_q) begin
                  state_d     = IDLE;
                  flushing_d  = 1'b0;
                  flush_ack_d = 1'b1;
               end else begin
                  state_d = COPY;
               end
            end
         end
         CLR: begin
            rd_d      = rd_wrapped;
            n_used_d  = n_used_q - clr_n;
            clr_ack_d = 1'b1;
            if (page_done) state_d = flushing_q ? FLUSH_PAD : COPY;
            else           state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (en_rise) begin
         first_d  = start_pg;
         last_d   = stop_pg;
         rd_d     = start_pg;
         wr_d     = start_pg;
         n_used_d = '0;
`ifdef HBUF_PG_STATS_EN
         stats_d  = '0;
`endif
      end
      busy_d = !en || copy_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         en_q        <= 1'b0;
         first_q     <= '0;
         last_q      <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         n_used_q    <= '0;
         fill_q      <= '0;
         hw_cnt_q    <= '0;
         hw_total_q  <= '0;
         copy_q      <= 1'b0;
         flushing_q  <= 1'b0;
         busy_q      <= 1'b0;
         clr_ack_q   <= 1'b0;
         flush_ack_q <= 1'b0;
`ifdef HBUF_PG_STATS_EN
         stats_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         en_q        <= en;
         first_q     <= first_d;
         last_q      <= last_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         n_used_q    <= n_used_d;
         fill_q      <= fill_d;
         hw_cnt_q    <= hw_cnt_d;
         hw_total_q  <= hw_total_d;
         copy_q      <= copy_d;
         flushing_q  <= flushing_d;
         busy_q      <= busy_d;
         clr_ack_q   <= clr_ack_d;
         flush_ack_q <= flush_ack_d;
`ifdef HBUF_PG_STATS_EN
         stats_q     <= stats_d;
`endif
      end
   end

   hbuf_page_ram u_page_ram (
      .clk     (clk),
      .wr_en   (pg_wr_en),
      .wr_addr (fill_q[PG_HW_AW-1:0]),
      .wr_data (pg_wr_data),
      .rd_addr (ddr3_dpram_rd_addr),
      .rd_data (ddr3_dpram_dout)
   );

   assign first_pg      = first_q;
   assign last_pg       = last_q;
   assign rd_pg_num     = rd_q;
   assign wr_pg_num     = wr_q;
   assign n_used_pgs    = n_used_q;
   assign empty         = (n_used_q == '0);
   assign full          = full_w;
   assign pg_clr_ack    = clr_ack_q;
   assign flush_ack     = flush_ack_q;
   assign buffered_data = (fill_q != '0);
   assign dpram_busy    = busy_q;
   assign pg_req        = (state_q == PG_REQ);
   assign pg_optype     = 1'b1;
   assign pg_addr       = P_ADDR_W'({wr_q, {PG_OFS_W{1'b0}}});
   assign dbg_state     = state_q;
`ifdef HBUF_PG_STATS_EN
   assign n_pgs_written = stats_q;
`endif
endmodule

// File: tb/tb_hbuf_controller.sv
// Self-checking bench for hbuf_controller: random records against a page-ring reference model.
`timescale 1ns/1ps
module tb_hbuf_controller;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic [15:0]  start_pg = '0, stop_pg = '0;
   logic [15:0]  first_pg, last_pg, rd_pg_num, wr_pg_num, n_used_pgs;
   logic         empty, full;
   logic         pg_clr_req = 1'b0;
   logic         pg_clr_ack;
   logic [15:0]  pg_clr_cnt = '0;
   logic         flush_req = 1'b0;
   logic         flush_ack, buffered_data;
   logic [15:0]  dpram_len_in = '0;
   logic         rdout_dpram_run = 1'b0;
   logic         dpram_busy;
   logic         rdout_dpram_wren = 1'b0;
   logic [7:0]   rdout_dpram_wr_addr = '0;
   logic [127:0] rdout_dpram_data = '0;
   logic [7:0]   ddr3_dpram_rd_addr = '0;
   logic [127:0] ddr3_dpram_dout;
   logic         pg_req;
   logic         pg_ack = 1'b0;
   logic         pg_optype;
   logic [27:0]  pg_addr;
   logic [2:0]   dbg_state;
`ifdef HBUF_PG_STATS_EN
   logic [31:0]  n_pgs_written;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: ring pointers plus the uncommitted half-words in write order.
   int          m_first, m_last, m_rd, m_wr, m_used;
   int          total_hw = 0;
   int          pages_committed = 0;
   logic [27:0] last_pg_addr = '0;
   logic [63:0] exp_q[$];

   hbuf_controller dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .start_pg(start_pg), .stop_pg(stop_pg),
      .first_pg(first_pg), .last_pg(last_pg),
      .rd_pg_num(rd_pg_num), .wr_pg_num(wr_pg_num), .n_used_pgs(n_used_pgs),
      .empty(empty), .full(full),
      .pg_clr_req(pg_clr_req), .pg_clr_ack(pg_clr_ack), .pg_clr_cnt(pg_clr_cnt),
      .flush_req(flush_req), .flush_ack(flush_ack), .buffered_data(buffered_data),
      .dpram_len_in(dpram_len_in), .rdout_dpram_run(rdout_dpram_run), .dpram_busy(dpram_busy),
      .rdout_dpram_wren(rdout_dpram_wren), .rdout_dpram_wr_addr(rdout_dpram_wr_addr),
      .rdout_dpram_data(rdout_dpram_data),
      .ddr3_dpram_rd_addr(ddr3_dpram_rd_addr), .ddr3_dpram_dout(ddr3_dpram_dout),
      .pg_req(pg_req), .pg_ack(pg_ack), .pg_optype(pg_optype), .pg_addr(pg_addr),
`ifdef HBUF_PG_STATS_EN
      .n_pgs_written(n_pgs_written),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int ring_next(input int p);
      return (p == m_last) ? m_first : p + 1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_busy_low(input int max_cyc, input string tag);
      int k;
      k = 0;
      while (dpram_busy && k < max_cyc) begin
         tick();
         k++;
      end
      check(tag, 128'(dpram_busy), 128'(0));
   endtask

   task automatic send_record(input int len_w);
      int nhw, ne;
      logic [127:0] ent;
      nhw = (len_w + 3) / 4;
      ne  = (nhw + 1) / 2;
      for (int e = 0; e < ne; e++) begin
         ent = {$urandom, $urandom, $urandom, $urandom};
         rdout_dpram_wren    = 1'b1;
         rdout_dpram_wr_addr = e[7:0];
         rdout_dpram_data    = ent;
         tick();
         exp_q.push_back(ent[63:0]);
         if (2 * e + 1 < nhw) exp_q.push_back(ent[127:64]);
      end
      rdout_dpram_wren = 1'b0;
      total_hw += nhw;
      dpram_len_in    = len_w[15:0];
      rdout_dpram_run = 1'b1;
      tick();
      rdout_dpram_run = 1'b0;
   endtask

   task automatic do_clear(input int cnt);
      int k, n;
      pg_clr_cnt = cnt[15:0];
      pg_clr_req = 1'b1;
      k = 0;
      while (!pg_clr_ack && k < 3000) begin
         tick();
         k++;
      end
      check("clr_ack", 128'(pg_clr_ack), 128'(1));
      n      = (cnt < m_used) ? cnt : m_used;
      m_rd   = m_first + (m_rd - m_first + n) % (m_last - m_first + 1);
      m_used = m_used - n;
      check("clr_rd", 128'(rd_pg_num), 128'(m_rd));
      check("clr_used", 128'(n_used_pgs), 128'(m_used));
      check("clr_wr", 128'(wr_pg_num), 128'(m_wr));
      pg_clr_req = 1'b0;
      k = 0;
      while (pg_clr_ack && k < 10) begin
         tick();
         k++;
      end
      check("clr_ack_drop", 128'(pg_clr_ack), 128'(0));
   endtask

   task automatic do_flush();
      int k, pad;
      pad = (exp_q.size() == 0) ? 0 : 512 - exp_q.size();
      for (int i = 0; i < pad; i++) exp_q.push_back(64'h0);
      flush_req = 1'b1;
      k = 0;
      while (!flush_ack && k < 3000) begin
         tick();
         k++;
      end
      check("flush_ack", 128'(flush_ack), 128'(1));
      check("flush_buffered", 128'(buffered_data), 128'(0));
      check("flush_used", 128'(n_used_pgs), 128'(m_used));
      check("flush_wr", 128'(wr_pg_num), 128'(m_wr));
      flush_req = 1'b0;
      k = 0;
      while (flush_ack && k < 10) begin
         tick();
         k++;
      end
      check("flush_ack_drop", 128'(flush_ack), 128'(0));
   endtask

   // ---------------- DDR3 writer side / scoreboard ----------------
   initial begin : responder
      logic [63:0] lo, hi;
      int k;
      forever begin
         tick();
         if (pg_req === 1'b1) begin
            check("pg_addr", 128'(pg_addr), 128'({m_wr[15:0], 12'h000}));
            check("pg_optype", 128'(pg_optype), 128'(1));
            last_pg_addr = pg_addr;
            for (int a = 0; a < 256; a++) begin
               ddr3_dpram_rd_addr = a[7:0];
               tick();
               lo = 64'hbad0_bad0_bad0_bad0;
               hi = 64'hbad1_bad1_bad1_bad1;
               if (exp_q.size() > 0) lo = exp_q.pop_front();
               if (exp_q.size() > 0) hi = exp_q.pop_front();
               check("page_data", ddr3_dpram_dout, {hi, lo});
            end
            m_wr = ring_next(m_wr);
            m_used++;
            pages_committed++;
            pg_ack = 1'b1;
            k = 0;
            while (pg_req && k < 50) begin
               tick();
               k++;
            end
            check("pg_req_drop", 128'(pg_req), 128'(0));
            pg_ack = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #800us;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int seen, len;
      repeat (3) tick();
      check("rst_empty", 128'(empty), 128'(1));
      check("rst_full", 128'(full), 128'(0));
      check("rst_pg_req", 128'(pg_req), 128'(0));
      check("rst_busy", 128'(dpram_busy), 128'(0));
      check("rst_used", 128'(n_used_pgs), 128'(0));
      check("rst_wr", 128'(wr_pg_num), 128'(0));
      check("rst_clr_ack", 128'(pg_clr_ack), 128'(0));
      check("rst_flush_ack", 128'(flush_ack), 128'(0));
      check("rst_buffered", 128'(buffered_data), 128'(0));

      rst_n = 1'b1;
      tick();
      tick();
      check("en0_busy", 128'(dpram_busy), 128'(1));
      dpram_len_in    = 16'd64;
      rdout_dpram_run = 1'b1;
      tick();
      rdout_dpram_run = 1'b0;
      repeat (4) tick();
      check("en0_run_ignored", 128'(buffered_data), 128'(0));

      start_pg = 16'd5;
      stop_pg  = 16'd15;
      m_first = 5; m_last = 15; m_rd = 5; m_wr = 5; m_used = 0;
      en = 1'b1;
      tick();
      tick();
      check("en_first", 128'(first_pg), 128'(5));
      check("en_last", 128'(last_pg), 128'(15));
      check("en_rd", 128'(rd_pg_num), 128'(5));
      check("en_wr", 128'(wr_pg_num), 128'(5));
      check("en_empty", 128'(empty), 128'(1));
      check("en_busy", 128'(dpram_busy), 128'(0));

      // Exactly one page (2048 words) split over records.
      send_record(500); wait_busy_low(3000, "rec_busy");
      send_record(500); wait_busy_low(3000, "rec_busy");
      send_record(500); wait_busy_low(3000, "rec_busy");
      send_record(548); wait_busy_low(3000, "rec_busy");
      check("pg1_addr", 128'(last_pg_addr), 128'(28'h0005000));
      check("pg1_wr", 128'(wr_pg_num), 128'(6));
      check("pg1_used", 128'(n_used_pgs), 128'(1));
      check("pg1_buffered", 128'(buffered_data), 128'(0));

      // Random records up to exactly eleven pages.
      while (total_hw + 512 < 11 * 512) begin
         len = $urandom_range(1, 2048);
         send_record(len);
         wait_busy_low(3000, "rand_busy");
      end
      send_record((11 * 512 - total_hw) * 4);
      wait_busy_low(3000, "fill_busy");
      check("fill_full", 128'(full), 128'(1));
      check("fill_used", 128'(n_used_pgs), 128'(11));
      check("fill_wr_wrap", 128'(wr_pg_num), 128'(5));
      check("fill_empty", 128'(empty), 128'(0));

      // Twelfth page stalls on the full ring until a clear.
      send_record(2048);
      seen = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (pg_req) seen++;
      end
      check("stall_no_req", 128'(seen), 128'(0));
      check("stall_busy", 128'(dpram_busy), 128'(1));
      check("stall_buffered", 128'(buffered_data), 128'(1));
      do_clear(100);
      check("clr100_rd", 128'(rd_pg_num), 128'(5));
      wait_busy_low(3000, "stall_resume");
      check("pg12_addr", 128'(last_pg_addr), 128'(28'h0005000));
      check("pg12_wr", 128'(wr_pg_num), 128'(6));
      check("pg12_used", 128'(n_used_pgs), 128'(1));

      // Partial page flush.
      send_record(100);
      wait_busy_low(3000, "flush_rec_busy");
      check("partial_buffered", 128'(buffered_data), 128'(1));
      do_flush();
      check("flush_pg_addr", 128'(last_pg_addr), 128'(28'h0006000));

      // Flush with nothing buffered: one-cycle ack, no page.
      flush_req = 1'b1;
      tick();
      check("flush_empty_ack", 128'(flush_ack), 128'(1));
      check("flush_empty_no_req", 128'(pg_req), 128'(0));
      flush_req = 1'b0;
      tick();
      check("flush_empty_drop", 128'(flush_ack), 128'(0));

      for (int r = 0; r < 4; r++) begin
         len = $urandom_range(1, 2048);
         send_record(len);
         wait_busy_low(3000, "mix_busy");
         do_clear($urandom_range(0, 3));
      end
      do_flush();
`ifdef HBUF_PG_STATS_EN
      check("stats_pages", 128'(n_pgs_written), 128'(pages_committed));
`endif

      // Reset in the middle of a copy drops everything.
      send_record(800);
      repeat (50) tick();
      rst_n = 1'b0;
      en    = 1'b0;
      tick();
      check("mid_rst_busy", 128'(dpram_busy), 128'(0));
      check("mid_rst_used", 128'(n_used_pgs), 128'(0));
      check("mid_rst_wr", 128'(wr_pg_num), 128'(0));
      check("mid_rst_buffered", 128'(buffered_data), 128'(0));
      check("mid_rst_empty", 128'(empty), 128'(1));
      check("mid_rst_pg_req", 128'(pg_req), 128'(0));
      rst_n = 1'b1;
      tick();
      tick();
      check("post_rst_busy", 128'(dpram_busy), 128'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
